// File: rtl/player_key_conditioner.sv
// Two-channel pushbutton conditioner: synchronize, debounce, and emit one-cycle press pulses L/R.
// Optional macro PLAYER_KEY_TIE_SUPPRESS_EN blanks both pulses when they coincide on the same cycle.
module player_key_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic key_l_n,
   input  logic key_r_n,
   output logic L,
   output logic R
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_e;

   logic [1:0] pressed;
   logic [1:0] fire;
   logic       l_d, r_d;
   logic       l_q, r_q;

   assign pressed = {~key_r_n, ~key_l_n};

   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      state_e                 state_q;
      logic [CW-1:0]          cnt_q;
      logic                   sync;

      // NOTE: the chain resets to "not pressed" so a held key after reset looks like a fresh press.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pressed[ch]};
         end
      end

      assign sync     = sync_q[SYNC_STAGES-1];
      assign fire[ch] = (state_q == PRESS_WAIT) && sync && (cnt_q == CNT_LAST);

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (sync) begin
                     state_q <= PRESS_WAIT;
                     cnt_q   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!sync) begin
                     state_q <= IDLE;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= HELD;
                  end else if (cnt_q != '1) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               HELD: begin
                  if (!sync) begin
                     state_q <= RELEASE_WAIT;
                     cnt_q   <= '0;
                  end
               end
               RELEASE_WAIT: begin
                  // A release bounce returns to HELD silently; it is never a new press.
                  if (sync) begin
                     state_q <= HELD;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= IDLE;
                  end else if (cnt_q != '1) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef PLAYER_KEY_TIE_SUPPRESS_EN
   assign l_d = fire[0] & ~fire[1];
   assign r_d = fire[1] & ~fire[0];
`else
   assign l_d = fire[0];
   assign r_d = fire[1];
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l_q <= 1'b0;
         r_q <= 1'b0;
      end else begin
         l_q <= l_d;
         r_q <= r_d;
      end
   end

   assign L = l_q;
   assign R = r_q;

endmodule

// File: tb/tb_player_key_conditioner.sv
// Scoreboard bench for player_key_conditioner: stimulus pushes expected pulses, a monitor pops and compares.
module tb_player_key_conditioner;

   typedef struct {
      int unsigned edge_no;
      logic        l;
      logic        r;
   } exp_t;

   logic clk;
   logic reset;
   logic key_l_n;
   logic key_r_n;
   logic L;
   logic R;

   int unsigned edge_cnt = 0;
   int          checks   = 0;
   int          errors   = 0;
   exp_t        exp_q[$];

   player_key_conditioner #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .key_l_n(key_l_n),
      .key_r_n(key_r_n),
      .L      (L),
      .R      (R)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic expect_pulse(input int unsigned edge_no, input logic l, input logic r);
      exp_t e;
      e.edge_no = edge_no;
      e.l       = l;
      e.r       = r;
      exp_q.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every pulse seen must match the oldest expected entry.
   always @(negedge clk) begin
      if (L === 1'b1 || R === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, L, R}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_edge", edge_cnt, e.edge_no);
            check("pulse_L", {31'd0, L}, {31'd0, e.l});
            check("pulse_R", {31'd0, R}, {31'd0, e.r});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned e0;
      logic [4:0]  r_pat;
      logic [2:0]  l_rel;

      // NOTE: inputs change only right after the falling edge, well clear of the sampling edge.
      reset   = 1'b0;
      key_l_n = 1'b1;
      key_r_n = 1'b1;

      // 1: reset and idle quiet
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset_quiet", {30'd0, L, R}, 32'd0);
      end
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_quiet", {30'd0, L, R}, 32'd0);
      end

      // 2: clean left press, held long
      e0 = edge_cnt;
      key_l_n = 1'b0;
      expect_pulse(e0 + 7, 1'b1, 1'b0);
      cycles(30);
      key_l_n = 1'b1;
      cycles(12);

      // 3: right key bounce, then stable press
      e0    = edge_cnt;
      r_pat = 5'b10010;  // driven LSB first: 0,1,0,0,1
      for (int i = 0; i < 5; i++) begin
         key_r_n = r_pat[i];
         @(negedge clk);
      end
      key_r_n = 1'b0;
      expect_pulse(e0 + 12, 1'b0, 1'b1);
      cycles(20);
      key_r_n = 1'b1;
      cycles(12);

      // 4: press, release bounce 1,0,1, sustained release, new press
      e0 = edge_cnt;
      key_l_n = 1'b0;
      expect_pulse(e0 + 7, 1'b1, 1'b0);
      cycles(12);
      l_rel = 3'b101;
      for (int i = 0; i < 3; i++) begin
         key_l_n = l_rel[i];
         @(negedge clk);
      end
      key_l_n = 1'b1;
      cycles(12);
      e0 = edge_cnt;
      key_l_n = 1'b0;
      expect_pulse(e0 + 7, 1'b1, 1'b0);
      cycles(12);
      key_l_n = 1'b1;
      cycles(12);

      // 5: simultaneous press
      e0 = edge_cnt;
      key_l_n = 1'b0;
      key_r_n = 1'b0;
`ifndef PLAYER_KEY_TIE_SUPPRESS_EN
      expect_pulse(e0 + 7, 1'b1, 1'b1);
`endif
      cycles(15);
      key_l_n = 1'b1;
      key_r_n = 1'b1;
      cycles(12);

      // 6: reset pulse mid-debounce discards the press; held key re-debounces
      e0 = edge_cnt;
      key_l_n = 1'b0;
      cycles(5);
      reset = 1'b0;
      #1;
      check("reset_mid_quiet", {30'd0, L, R}, 32'd0);
      #1;
      reset = 1'b1;
      expect_pulse(e0 + 12, 1'b1, 1'b0);
      cycles(15);
      key_l_n = 1'b1;
      cycles(12);

      check("missing_pulses", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
